alu_ctrl_fsm: RTL
=================

Name: alu_ctrl_fsm

Overview:
Multicycle control unit that drives the ALU's alu_op interface and the datapath strobes around it.
- Latches each RV32I instruction.
- Decodes opcode/funct3/funct7 into the 4-bit ALU operation code.
- Sequences IF/ID/EX/MEM/WB.
- Consumes the ALU zero flag for BEQ.
- Sits between instruction/data memory handshakes and the register file/ALU datapath.

Parameters:
- RESET_PC_WRITE, 0, when 1 pc_write pulses once in the first IF after reset (skips the reset vector); default 0.
- MEM_TIMEOUT, 0, cycles to wait in MEM before forcing illegal and returning to IF; 0 = wait forever.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- instr  input  32  instruction word from instruction memory, valid in IF.
- zero  input  1  ALU zero flag, sampled in EX.
- mem_ready  input  1  data memory completion strobe.
- alu_op  output  4  ALU operation code.
- alu_src_imm  output  1  1 = op2 is the immediate, 0 = op2 is rs2.
- ir_load  output  1  latch instr into the IR this cycle.
- reg_write  output  1  register file write enable.
- mem_read  output  1  data memory read request.
- mem_write  output  1  data memory write request.
- mem_to_reg  output  1  writeback source is memory.
- pc_write  output  1  PC update strobe.
- pc_branch  output  1  PC source is the branch target, qualified by pc_write.
- illegal  output  1  one-cycle pulse on an undecodable instruction or MEM timeout.
- instr_count  output  32  retired-instruction count (see Optional Feature).

Behaviour:
- States: IF, ID, EX, MEM, WB. Reset enters IF; the internal IR clears to 0.
- Outputs are a function of state and IR. All outputs are 0 while rst is high.
- IF: ir_load=1; the IR captures instr at the clock edge; next state is ID.
- ID: decode. Illegal opcode -> illegal=1 for one cycle, next state IF, no pc_write, no other strobes. Otherwise next state is EX.
- EX: alu_op is valid for the whole state.
  - R-type (0110011), alu_src_imm=0: funct3/funct7 map as follows.
    - 000/0000000 -> 0010 (ADD).
    - 000/0100000 -> 0110 (SUB).
    - 010 -> 0100 (SLT).
    - 100 -> 0101 (XOR).
    - 110 -> 0001 (OR).
    - 111 -> 0000 (AND).
    - 001 -> 1001 (SLL).
    - 101/0000000 -> 1000 (SRL).
    - 101/0100000 -> 1010 (SRA).
    - Any other funct7 -> illegal.
  - I-type ALU (0010011), alu_src_imm=1: same funct3 map. funct7 is checked only for funct3 001/101. ADDI never maps to SUB.
  - LW (0000011) and SW (0100011): alu_op=0010, alu_src_imm=1. funct3 must be 010, else illegal.
  - BEQ (1100011, funct3 000): alu_op=0110, alu_src_imm=0. pc_write=1 in EX; pc_branch=zero. Next state IF. Other funct3 -> illegal.
  - R/I next state is WB; LW/SW next state is MEM.
- MEM:
  - mem_read (LW) or mem_write (SW) is held while mem_ready=0.
  - On mem_ready=1: LW -> WB; SW -> pc_write=1, then IF.
  - mem_ready is ignored in all other states.
- WB: reg_write=1 and pc_write=1 for one cycle; mem_to_reg=1 for LW only; next state IF.
- Latency (cycles): R/I 4; BEQ 3; SW 4+stall; LW 5+stall.
- alu_op default, outside EX or when undecodable: 0000.
- Exactly one pc_write per retired instruction; none for illegal instructions.
- Reset mid-operation (any state, including a MEM stall): immediate return to IF. Pending memory requests drop the same cycle.
- MEM_TIMEOUT>0: counter cleared on MEM entry. At MEM_TIMEOUT cycles without mem_ready: illegal pulse, return to IF, no pc_write.

Optional Feature:
- Macro: ALU_CTRL_PERF_CNT_EN.
- Defined: instr_count is a 32-bit counter.
  - Reset to 0; increments on every pc_write; wraps 0xFFFFFFFF -> 0.
  - Illegal instructions do not count.
- Undefined: instr_count is tied to 0 and no counter flops exist.

Decomposition:
- Shared package alu_ctrl_pkg:
  - Opcode constants.
  - The nine 4-bit ALU operation codes above; the ALU is re-pointed at the same package.
  - State enum.
- One sub-module, alu_op_decode: combinational opcode/funct3/funct7 -> {alu_op, legal}, instantiated once.

Test Plan:
- ADD 0x002081B3 after reset -> IF,ID,EX,WB; alu_op=0010 in EX; reg_write and pc_write pulse in WB; 4 cycles.
- SUB 0x402081B3, then SRAI 0x40335293 -> EX alu_op=0110 (alu_src_imm=0), then 1010 (alu_src_imm=1).
- LW 0x00012083 with mem_ready held low 3 cycles -> mem_read held 4 cycles; WB has mem_to_reg=1; total 8 cycles.
- SW 0x00112223 -> mem_write until mem_ready; pc_write pulses on the mem_ready cycle; reg_write stays 0.
- BEQ 0x00208463 with zero=1, then zero=0 -> both pc_write in EX; pc_branch 1 then 0; 3 cycles each.
- instr 0xFFFFFFFF -> illegal pulse in ID, no pc_write, instr_count unchanged. rst asserted during a LW MEM stall -> all outputs 0 immediately; IF after release.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : alu_ctrl_pkg
// Purpose : Shared definitions for the multicycle ALU control unit and the ALU
//           itself: RV32I opcode constants, the 4-bit ALU operation codes and
//           the control FSM state encoding.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package alu_ctrl_pkg;

  // RV32I major opcodes handled by the control unit
  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // funct7 variants that select the alternate operation (SUB / SRA)
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // Funct3 values with fixed meaning for memory and branch instructions
  localparam logic [2:0] F3_WORD = 3'b010;
  localparam logic [2:0] F3_BEQ  = 3'b000;

  // ALU operation codes
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SLT = 4'b0100;
  localparam logic [3:0] ALU_XOR = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SRL = 4'b1000;
  localparam logic [3:0] ALU_SLL = 4'b1001;
  localparam logic [3:0] ALU_SRA = 4'b1010;

  // Multicycle sequencing states
  typedef enum logic [2:0] {
    ST_IF  = 3'd0,
    ST_ID  = 3'd1,
    ST_EX  = 3'd2,
    ST_MEM = 3'd3,
    ST_WB  = 3'd4
  } state_e;

  // Base ALU operation selected by funct3 for register/immediate ALU ops.
  // Returns {supported, alu_op}; funct3 011 (SLTU) is not supported.
  function automatic logic [4:0] f3_base_op(input logic [2:0] f3);
    logic [4:0] r;
    case (f3)
      3'b000:  r = {1'b1, ALU_ADD};
      3'b001:  r = {1'b1, ALU_SLL};
      3'b010:  r = {1'b1, ALU_SLT};
      3'b100:  r = {1'b1, ALU_XOR};
      3'b101:  r = {1'b1, ALU_SRL};
      3'b110:  r = {1'b1, ALU_OR};
      3'b111:  r = {1'b1, ALU_AND};
      default: r = {1'b0, ALU_AND};
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_op_decode.sv
`default_nettype none
// ============================================================================
// Module  : alu_op_decode
// Purpose : Combinational RV32I opcode/funct3/funct7 decode into the 4-bit
//           ALU operation code plus a legality flag.
// Ports   : opcode [6:0]  - instruction major opcode
//           funct3 [2:0]  - instruction funct3 field
//           funct7 [6:0]  - instruction funct7 field
//           alu_op [3:0]  - decoded ALU operation (AND/0000 when illegal)
//           legal         - 1 when the instruction is supported
// Revision: 1.0 - initial release
// ============================================================================
module alu_op_decode
  import alu_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic [3:0] alu_op,
  output logic       legal
);

  logic [4:0] base;

  assign base = f3_base_op(funct3);

  always_comb begin
    alu_op = ALU_AND;
    legal  = 1'b0;
    case (opcode)
      OPC_RTYPE: begin
        if (base[4]) begin
          if (funct7 == F7_BASE) begin
            legal  = 1'b1;
            alu_op = base[3:0];
          end else if (funct7 == F7_ALT) begin
            // Only ADD and SRL have an alternate (SUB / SRA) form
            if (funct3 == 3'b000) begin
              legal  = 1'b1;
              alu_op = ALU_SUB;
            end else if (funct3 == 3'b101) begin
              legal  = 1'b1;
              alu_op = ALU_SRA;
            end
          end
        end
      end
      OPC_ITYPE: begin
        // Upper immediate bits are only an opcode qualifier for shifts;
        // ADDI therefore never becomes SUB.
        if (base[4]) begin
          case (funct3)
            3'b001: begin
              legal  = (funct7 == F7_BASE);
              alu_op = (funct7 == F7_BASE) ? ALU_SLL : ALU_AND;
            end
            3'b101: begin
              if (funct7 == F7_BASE) begin
                legal  = 1'b1;
                alu_op = ALU_SRL;
              end else if (funct7 == F7_ALT) begin
                legal  = 1'b1;
                alu_op = ALU_SRA;
              end
            end
            default: begin
              legal  = 1'b1;
              alu_op = base[3:0];
            end
          endcase
        end
      end
      OPC_LOAD, OPC_STORE: begin
        if (funct3 == F3_WORD) begin
          legal  = 1'b1;
          alu_op = ALU_ADD;
        end
      end
      OPC_BRANCH: begin
        if (funct3 == F3_BEQ) begin
          legal  = 1'b1;
          alu_op = ALU_SUB;
        end
      end
      default: begin
        alu_op = ALU_AND;
        legal  = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module  : alu_ctrl_fsm
// Purpose : Multicycle RV32I control unit. Latches each instruction, decodes
//           it to an ALU operation and sequences IF/ID/EX/MEM/WB, driving
//           the datapath and memory strobes.
// Ports   : clk, rst (async, active-high)
//           instr[31:0]  - instruction word, sampled in IF
//           zero         - ALU zero flag, used by BEQ in EX
//           mem_ready    - data memory completion, used in MEM only
//           alu_op[3:0], alu_src_imm, ir_load, reg_write, mem_read,
//           mem_write, mem_to_reg, pc_write, pc_branch, illegal
//           instr_count[31:0] - retired-instruction counter
// Params  : RESET_PC_WRITE - pulse pc_write in the first IF after reset
//           MEM_TIMEOUT    - MEM wait limit in cycles (0 = no limit)
// Macro   : ALU_CTRL_PERF_CNT_EN - enables the instr_count counter;
//           otherwise instr_count is tied to 0.
// Revision: 1.0 - initial release
// ============================================================================
module alu_ctrl_fsm
  import alu_ctrl_pkg::*;
#(
  parameter bit          RESET_PC_WRITE = 1'b0,
  parameter int unsigned MEM_TIMEOUT    = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        zero,
  input  logic        mem_ready,
  output logic [3:0]  alu_op,
  output logic        alu_src_imm,
  output logic        ir_load,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_to_reg,
  output logic        pc_write,
  output logic        pc_branch,
  output logic        illegal,
  output logic [31:0] instr_count
);

  state_e      state_q, state_d;
  logic [31:0] ir_q, ir_d;
  logic        first_if_q, first_if_d;

  logic [3:0]  dec_alu_op;
  logic        dec_legal;
  logic        timeout_hit;

  logic [6:0]  opcode;
  logic        is_itype, is_load, is_store, is_branch;

  assign opcode    = ir_q[6:0];
  assign is_itype  = (opcode == OPC_ITYPE);
  assign is_load   = (opcode == OPC_LOAD);
  assign is_store  = (opcode == OPC_STORE);
  assign is_branch = (opcode == OPC_BRANCH);

  // Register/immediate operand fields are consumed by the datapath, not here
  logic unused_ir_bits;
  assign unused_ir_bits = ^{ir_q[24:15], ir_q[11:7]};

  alu_op_decode u_decode (
    .opcode (ir_q[6:0]),
    .funct3 (ir_q[14:12]),
    .funct7 (ir_q[31:25]),
    .alu_op (dec_alu_op),
    .legal  (dec_legal)
  );

  // --------------------------------------------------------------------------
  // MEM wait limit. The counter sits at 0 outside MEM, so it is clear on
  // every MEM entry; the limit fires on the MEM_TIMEOUT-th cycle without
  // mem_ready.
  // --------------------------------------------------------------------------
  generate
    if (MEM_TIMEOUT > 0) begin : g_timeout
      localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
      logic [CW-1:0] tmo_cnt_q, tmo_cnt_d;

      always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (state_q != ST_MEM) begin
          tmo_cnt_d = '0;
        end else if (!mem_ready) begin
          tmo_cnt_d = tmo_cnt_q + CW'(1);
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          tmo_cnt_q <= '0;
        end else begin
          tmo_cnt_q <= tmo_cnt_d;
        end
      end

      assign timeout_hit = (state_q == ST_MEM) && !mem_ready &&
                           (tmo_cnt_q == CW'(MEM_TIMEOUT - 1));
    end else begin : g_no_timeout
      assign timeout_hit = 1'b0;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Next-state / IR capture
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    first_if_d = first_if_q;
    case (state_q)
      ST_IF: begin
        ir_d       = instr;
        first_if_d = 1'b0;
        state_d    = ST_ID;
      end
      ST_ID: begin
        state_d = dec_legal ? ST_EX : ST_IF;
      end
      ST_EX: begin
        if (is_branch) begin
          state_d = ST_IF;
        end else if (is_load || is_store) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        if (mem_ready) begin
          state_d = is_load ? ST_WB : ST_IF;
        end else if (timeout_hit) begin
          state_d = ST_IF;
        end
      end
      ST_WB: begin
        state_d = ST_IF;
      end
      default: begin
        state_d = ST_IF;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IF;
      ir_q       <= '0;
      first_if_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      ir_q       <= ir_d;
      first_if_q <= first_if_d;
    end
  end

  // --------------------------------------------------------------------------
  // Output decode from the registered state and IR. Decoding from state
  // (rather than re-registering) lets ir_load assert in the very first IF
  // after reset, and the rst term drops every strobe, including a pending
  // memory request, in the same cycle reset is raised.
  // --------------------------------------------------------------------------
  always_comb begin
    alu_op      = ALU_AND;
    alu_src_imm = 1'b0;
    ir_load     = 1'b0;
    reg_write   = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_to_reg  = 1'b0;
    pc_write    = 1'b0;
    pc_branch   = 1'b0;
    illegal     = 1'b0;
    if (!rst) begin
      case (state_q)
        ST_IF: begin
          ir_load  = 1'b1;
          pc_write = RESET_PC_WRITE && first_if_q;
        end
        ST_ID: begin
          illegal = !dec_legal;
        end
        ST_EX: begin
          alu_op      = dec_alu_op;
          alu_src_imm = is_itype || is_load || is_store;
          if (is_branch) begin
            pc_write  = 1'b1;
            pc_branch = zero;
          end
        end
        ST_MEM: begin
          mem_read  = is_load;
          mem_write = is_store;
          pc_write  = is_store && mem_ready;
          illegal   = timeout_hit;
        end
        ST_WB: begin
          reg_write  = 1'b1;
          pc_write   = 1'b1;
          mem_to_reg = is_load;
        end
        default: begin
          alu_op = ALU_AND;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Retired-instruction counter
  // --------------------------------------------------------------------------
`ifdef ALU_CTRL_PERF_CNT_EN
  logic [31:0] instr_count_q, instr_count_d;

  always_comb begin
    instr_count_d = instr_count_q;
    if (pc_write) begin
      instr_count_d = instr_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_count_q <= '0;
    end else begin
      instr_count_q <= instr_count_d;
    end
  end

  assign instr_count = instr_count_q;
`else
  assign instr_count = '0;
`endif

endmodule
`default_nettype wire
